// File: rtl/shift_pkg.sv
// Shared constants and types for the shift arbiter slice.
// Opcode encodings, datapath width and FSM state encoding.
package shift_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int SHAMT_W    = 5;

    localparam logic [1:0] SHIFTOP_LEFT      = 2'b00;
    localparam logic [1:0] SHIFTOP_RIGHT_LOG = 2'b10;
    localparam logic [1:0] SHIFTOP_RIGHT_ART = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [SHAMT_W-1:0]    b;
        logic [1:0]            op;
    } shift_req_t;

endpackage

// File: rtl/shifter.sv
// Combinational 32-bit shifter: left, logical right, arithmetic right.
// Opcode 01 is undefined and yields zero.
module shifter
    import shift_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [SHAMT_W-1:0]    b,
    input  logic [1:0]            op,
    output logic [DATA_WIDTH-1:0] result
);

    // Select the shift flavour; the undefined opcode returns zero
    always_comb begin
        result = '0;
        unique case (op)
            SHIFTOP_LEFT:      result = a << b;
            SHIFTOP_RIGHT_LOG: result = a >> b;
            SHIFTOP_RIGHT_ART: result = $unsigned($signed(a) >>> b);
            default:           result = '0;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared shifter, 1-cycle latency.
// Define SHIFT_ARB_RR_EN for round-robin; default is fixed priority (port 0).
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH = shift_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [4:0]            req0_b,
    input  logic [1:0]            req0_op,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [4:0]            req1_b,
    input  logic [1:0]            req1_op,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_id,

    output logic                  busy
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_id_q, rsp_id_d;

    logic       grant0, grant1;
    logic       accept;
    logic       xfer0, xfer1, xfer;
    shift_req_t sel_req;
    logic [DATA_WIDTH-1:0] sh_result;

`ifdef SHIFT_ARB_RR_EN
    // ptr_q high means port 1 wins the next contention
    logic ptr_q, ptr_d;
`endif

    // Pick a winner from the current valids
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef SHIFT_ARB_RR_EN
        unique case (1'b1)
            (req0_valid & req1_valid): begin
                grant0 = ~ptr_q;
                grant1 = ptr_q;
            end
            (req0_valid & ~req1_valid): grant0 = 1'b1;
            (~req0_valid & req1_valid): grant1 = 1'b1;
            default: ;
        endcase
`else
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
`endif
    end

    // Accept a new request when the response slot is free or draining
    always_comb begin
        accept = resetn & ((state_q == ST_IDLE) | rsp_ready);
        req0_ready = grant0 & accept;
        req1_ready = grant1 & accept;
        xfer0 = req0_valid & req0_ready;
        xfer1 = req1_valid & req1_ready;
        xfer  = xfer0 | xfer1;
    end

    // Steer the granted payload into the shared shifter
    always_comb begin
        sel_req = '0;
        if (grant1) begin
            sel_req.a  = req1_a;
            sel_req.b  = req1_b;
            sel_req.op = req1_op;
        end else begin
            sel_req.a  = req0_a;
            sel_req.b  = req0_b;
            sel_req.op = req0_op;
        end
    end

    shifter u_shifter (
        .a      (sel_req.a),
        .b      (sel_req.b),
        .op     (sel_req.op),
        .result (sh_result)
    );

    // Next state and response capture
    always_comb begin
        state_d      = state_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = xfer ? ST_RESP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (xfer) begin
            rsp_result_d = sh_result;
            rsp_id_d     = xfer1;
        end
    end

`ifdef SHIFT_ARB_RR_EN
    // Hand priority to the port that did not just win
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) ptr_d = xfer0;
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ptr_q <= 1'b0;
        else         ptr_q <= ptr_d;
    end
`endif

    // State and response registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q == ST_RESP);
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter; works in both arbitration builds.
// Define SHIFT_ARB_RR_EN to check the round-robin build.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a;
    logic [4:0]  req0_b;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a;
    logic [4:0]  req1_b;
    logic [1:0]  req1_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_id;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [32:0] sb_q[$];
    bit rr_pri = 1'b0;

    shift_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_win(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef SHIFT_ARB_RR_EN
            return rr_pri ? 1 : 0;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic note_win(input int p);
        rr_pri = (p == 0);
    endtask

    // Monitor: every accepted response is popped and compared
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            if (resetn && rsp_valid && rsp_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%0d result=%h expected none",
                             rsp_id, rsp_result);
                end else begin
                    exp = sb_q.pop_front();
                    if ({rsp_id, rsp_result} !== exp) begin
                        errors++;
                        $display("FAIL rsp: got id=%0d result=%h expected id=%0d result=%h",
                                 rsp_id, rsp_result, exp[32], exp[31:0]);
                    end
                end
            end
        end
    end

    // Present one request, wait for acceptance, push the expected response
    task automatic issue(input int p, input logic [31:0] a, input logic [4:0] b,
                         input logic [1:0] op, input logic [31:0] exp);
        bit done = 1'b0;
        if (p == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
                sb_q.push_back({p[0], exp});
                note_win(p);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (p == 0) req0_valid = 1'b0;
        else        req1_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: port %0d got no ready expected ready", p);
        end else begin
            check("latency_valid", {31'b0, rsp_valid}, 32'h1);
        end
    endtask

    initial begin
        int k0, k1, w;
        logic [31:0] a0, a1;

        resetn = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h1; req0_b = 5'd1; req0_op = 2'b00;
        req1_valid = 1'b1; req1_a = 32'h2; req1_b = 5'd1; req1_op = 2'b00;
        #3;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_result", rsp_result, 32'h0);
        check("rst_id", {31'b0, rsp_id}, 32'h0);
        check("rst_ready0", {31'b0, req0_ready}, 32'h0);
        check("rst_ready1", {31'b0, req1_ready}, 32'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        rsp_ready = 1'b1;
        issue(0, 32'h8000_0000, 5'd4, 2'b11, 32'hF800_0000);
        issue(1, 32'h8000_0000, 5'd4, 2'b10, 32'h0800_0000);
        issue(1, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
        issue(1, 32'hDEAD_BEEF, 5'd7, 2'b01, 32'h0000_0000);
        issue(0, 32'h1234_5678, 5'd0, 2'b11, 32'h1234_5678);
        issue(0, 32'h1234_5678, 5'd0, 2'b10, 32'h1234_5678);
        issue(1, 32'h1234_5678, 5'd0, 2'b00, 32'h1234_5678);
        issue(0, 32'h7000_0000, 5'd4, 2'b11, 32'h0700_0000);
        issue(0, 32'h8000_0001, 5'd31, 2'b10, 32'h0000_0001);
        issue(0, 32'h8000_0001, 5'd31, 2'b11, 32'hFFFF_FFFF);
        issue(1, 32'hF000_0001, 5'd4, 2'b00, 32'h0000_0010);

        // Contention: both valid every cycle, losers hold their payload
        k0 = 0;
        k1 = 0;
        for (int c = 0; c < 4; c++) begin
            a0 = 32'hA000_0000 | k0;
            a1 = 32'hB000_0000 | k1;
            req0_a = a0; req0_b = 5'd0; req0_op = 2'b00; req0_valid = 1'b1;
            req1_a = a1; req1_b = 5'd0; req1_op = 2'b00; req1_valid = 1'b1;
            @(negedge clk);
            w = model_win(1'b1, 1'b1);
            check("cont_ready0", {31'b0, req0_ready}, {31'b0, w == 0});
            check("cont_ready1", {31'b0, req1_ready}, {31'b0, w == 1});
            sb_q.push_back({w[0], (w == 1) ? a1 : a0});
            note_win(w);
            @(posedge clk);
            #1;
            if (w == 0) k0++;
            else        k1++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: held response stays put, no new transfers
        rsp_ready = 1'b0;
        issue(0, 32'hFFFF_0000, 5'd8, 2'b10, 32'h00FF_FF00);
        req1_a = 32'h3; req1_b = 5'd1; req1_op = 2'b00; req1_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_valid", {31'b0, rsp_valid}, 32'h1);
            check("stall_result", rsp_result, 32'h00FF_FF00);
            check("stall_id", {31'b0, rsp_id}, 32'h0);
            check("stall_busy", {31'b0, busy}, 32'h1);
            check("stall_ready0", {31'b0, req0_ready}, 32'h0);
            check("stall_ready1", {31'b0, req1_ready}, 32'h0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("release_ready1", {31'b0, req1_ready}, 32'h1);
        sb_q.push_back({1'b1, 32'h0000_0006});
        note_win(1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a response is held: it must vanish
        rsp_ready = 1'b0;
        issue(0, 32'h0000_000F, 5'd2, 2'b00, 32'h0000_003C);
        req0_a = 32'h0000_0001; req0_b = 5'd1; req0_op = 2'b00; req0_valid = 1'b1;
        req1_a = 32'h0000_0010; req1_b = 5'd1; req1_op = 2'b10; req1_valid = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_valid", {31'b0, rsp_valid}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_result", rsp_result, 32'h0);
        check("midrst_id", {31'b0, rsp_id}, 32'h0);
        check("midrst_ready0", {31'b0, req0_ready}, 32'h0);
        check("midrst_ready1", {31'b0, req1_ready}, 32'h0);
        sb_q.delete();
        rr_pri = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        w = model_win(1'b1, 1'b1);
        check("postrst_ready0", {31'b0, req0_ready}, {31'b0, w == 0});
        check("postrst_ready1", {31'b0, req1_ready}, {31'b0, w == 1});
        sb_q.push_back({1'b0, 32'h0000_0002});
        note_win(w);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("postrst_valid", {31'b0, rsp_valid}, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
